// File: rtl/ens_pkg.sv
// rtl/ens_pkg.sv - shared types, default sizes and width helper for the ensemble output stage
package ens_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SCAN  = 2'd1,
        ST_HOLD  = 2'd2
    } ens_state_e;

    localparam int DEF_NUM_ENS     = 4;
    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_SCORE_W     = 2;

    // Wide enough that num_ens maximum scores can never wrap.
    function automatic int sum_width(input int score_w, input int num_ens);
        return score_w + $clog2(num_ens);
    endfunction

endpackage

// File: rtl/ens_score_acc_bank.sv
// rtl/ens_score_acc_bank.sv - per-class score accumulators with indexed read port
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (clears all sums)
//   load_i        overwrite every sum with the incoming score (first member of a sample)
//   add_i         add the incoming score to every sum (later members)
//   scores_i      packed per-class scores, class c at [c*SCORE_W +: SCORE_W]
//   rd_idx_i      class index to read
//   rd_sum_o      sum of class rd_idx_i (zero for out-of-range indices)
module ens_score_acc_bank #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 2,
    parameter int SUM_W       = 4,
    parameter int IDX_W       = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load_i,
    input  logic                           add_i,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores_i,
    input  logic [IDX_W-1:0]               rd_idx_i,
    output logic [SUM_W-1:0]               rd_sum_o
);

    logic [SUM_W-1:0] sum_q [NUM_CLASSES];
    logic [SUM_W-1:0] score_ext [NUM_CLASSES];

    always_comb begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
            score_ext[c] = SUM_W'(scores_i[c*SCORE_W +: SCORE_W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                sum_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (load_i) begin
                    sum_q[c] <= score_ext[c];
                end else if (add_i) begin
                    sum_q[c] <= sum_q[c] + score_ext[c];
                end
            end
        end
    end

    always_comb begin
        rd_sum_o = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (rd_idx_i == IDX_W'(c)) begin
                rd_sum_o = sum_q[c];
            end
        end
    end

endmodule

// File: rtl/ens_score_argmax.sv
// rtl/ens_score_argmax.sv - sums ensemble member scores per class and emits the argmax class
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   s_valid/s_ready    one ensemble member score vector per accepted beat
//   s_scores           packed per-class scores, class c at [c*SCORE_W +: SCORE_W]
//   m_valid/m_ready    result handshake
//   m_class, m_score   winning class index and its summed score
module ens_score_argmax
    import ens_pkg::*;
#(
    parameter int NUM_ENS     = DEF_NUM_ENS,
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int SCORE_W     = DEF_SCORE_W,
    localparam int SUM_W      = sum_width(SCORE_W, NUM_ENS),
    localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [NUM_CLASSES*SCORE_W-1:0] s_scores,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [IDX_W-1:0]               m_class,
    output logic [SUM_W-1:0]               m_score
);

    localparam int               CNT_W    = $clog2(NUM_ENS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ENS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    ens_state_e       state_q, state_d;
    logic [CNT_W-1:0] ens_cnt_q, ens_cnt_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic [SUM_W-1:0] best_q, best_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             acc_load, acc_add;
    logic [SUM_W-1:0] rd_sum;

    ens_score_acc_bank #(
        .NUM_CLASSES (NUM_CLASSES),
        .SCORE_W     (SCORE_W),
        .SUM_W       (SUM_W),
        .IDX_W       (IDX_W)
    ) u_acc_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (acc_load),
        .add_i    (acc_add),
        .scores_i (s_scores),
        .rd_idx_i (scan_idx_q),
        .rd_sum_o (rd_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACCUM;
            ens_cnt_q  <= '0;
            scan_idx_q <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ens_cnt_q  <= ens_cnt_d;
            scan_idx_q <= scan_idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ens_cnt_d  = ens_cnt_q;
        scan_idx_d = scan_idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        acc_load   = 1'b0;
        acc_add    = 1'b0;

        unique case (state_q)
            ST_ACCUM: begin
                // s_ready is 1 here, so s_valid alone is the handshake.
                if (s_valid) begin
                    acc_load = (ens_cnt_q == '0);
                    acc_add  = (ens_cnt_q != '0);
                    if (ens_cnt_q == LAST_CNT) begin
                        ens_cnt_d  = '0;
                        scan_idx_d = '0;
                        state_d    = ST_SCAN;
                    end else begin
                        ens_cnt_d = ens_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if (scan_idx_q == '0 || rd_sum > best_q) begin
                    best_d     = rd_sum;
                    best_idx_d = scan_idx_q;
                end
                if (scan_idx_q == LAST_IDX) begin
                    state_d = ST_HOLD;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_W'(1);
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // Handshake outputs come straight from the state register.
    assign s_ready = (state_q == ST_ACCUM);
    assign m_valid = (state_q == ST_HOLD);
    assign m_class = best_idx_q;
    assign m_score = best_q;

endmodule

// File: tb/tb_ens_score_argmax.sv
// tb/tb_ens_score_argmax.sv - scoreboard bench for ens_score_argmax with directed samples
module tb_ens_score_argmax;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [19:0] s_scores;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_class;
    logic [3:0]  m_score;

    typedef struct {
        int cls;
        int score;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_miss   = 0;

    ens_score_argmax dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_scores (s_scores),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_class  (m_class),
        .m_score  (m_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    function automatic logic [19:0] sc(input int c, input int v);
        logic [19:0] r;
        r = '0;
        r[c*2 +: 2] = 2'(v);
        return r;
    endfunction

    // Monitor: every consumed result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_class", int'(m_class), e.cls);
                check("result_score", int'(m_score), e.score);
            end
        end
    end

    // Drive a beat at posedge+1 and hold it until it is accepted.
    task automatic beat(input logic [19:0] v);
        int n;
        n = 0;
        s_valid  = 1'b1;
        s_scores = v;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ready && n < 100);
        check("beat_accept", int'(s_ready), 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int s);
        exp_t e;
        e.cls   = c;
        e.score = s;
        sb.push_back(e);
    endtask

    logic [19:0] t2 [4];
    int          lat;
    logic [3:0]  cap_cls;
    logic [3:0]  cap_score;

    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_scores = '0;
        m_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_s_ready", int'(s_ready), 1);
        check("reset_m_valid", int'(m_valid), 0);
        check("reset_m_class", int'(m_class), 0);
        check("reset_m_score", int'(m_score), 0);
        rst_n = 1'b1;
        idle(1);

        // Class 7 scores 3 in every beat; check latency to m_valid.
        push(7, 12);
        for (int i = 0; i < 4; i++) beat(sc(7, 3));
        lat = 0;
        @(negedge clk);
        while (!m_valid && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        check("valid_latency", lat, 10);
        wait_drain();

        // Classes 2 and 5 tie at 6; lowest index wins.
        t2[0] = sc(2, 3) | sc(5, 3) | sc(0, 1);
        t2[1] = sc(2, 3) | sc(5, 1) | sc(9, 2);
        t2[2] = sc(5, 2) | sc(0, 2);
        t2[3] = sc(1, 3);
        push(2, 6);
        for (int i = 0; i < 4; i++) beat(t2[i]);
        wait_drain();

        // Same sample with idle gaps, plus s_valid held high through SCAN.
        push(2, 6);
        for (int i = 0; i < 4; i++) begin
            beat(t2[i]);
            if (i < 3) idle(i);
        end
        s_valid  = 1'b1;
        s_scores = 20'hFFFFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("scan_s_ready", int'(s_ready), 0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        wait_drain();

        // Stall in HOLD with m_ready low and s_valid high.
        m_ready = 1'b0;
        push(9, 8);
        for (int i = 0; i < 4; i++) beat(sc(9, 2));
        lat = 0;
        @(negedge clk);
        while (!m_valid && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        check("stall_valid_seen", int'(m_valid), 1);
        cap_cls   = m_class;
        cap_score = m_score;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            s_valid  = 1'b1;
            s_scores = 20'hFFFFF;
            @(negedge clk);
            check("stall_m_valid", int'(m_valid), 1);
            check("stall_s_ready", int'(s_ready), 0);
            check("stall_class", int'(m_class), int'(cap_cls));
            check("stall_score", int'(m_score), int'(cap_score));
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_m_valid", int'(m_valid), 0);
        check("release_s_ready", int'(s_ready), 1);
        wait_drain();

        // Reset mid-scan discards the sample; next one starts clean.
        for (int i = 0; i < 4; i++) beat(sc(9, 3) | sc(4, 3));
        idle(3);
        rst_n = 1'b0;
        @(negedge clk);
        check("midscan_rst_m_valid", int'(m_valid), 0);
        check("midscan_rst_s_ready", int'(s_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        push(4, 4);
        for (int i = 0; i < 4; i++) beat(sc(4, 1));
        wait_drain();

        // All-zero scores.
        push(0, 0);
        for (int i = 0; i < 4; i++) beat(20'h0);
        wait_drain();

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
